// File: rtl/uart_relay_fifo.sv
// UART relay: frames received on rx are buffered in a FIFO and re-sent on tx.
// One clock domain; rx is synchronised, tx is driven from a register.
module uart_relay_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx,
    output logic                        tx,
    input  logic                        clr_flags,
    output logic                        overflow,
    output logic                        frame_err,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_M1   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_M1  = CW'(CLKS_PER_BIT - 2);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [AW:0]   FULL     = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

    logic                 r_rx_meta, r_rx_sync, r_rx_prev;
    rx_state_t            r_rx_state, w_rx_state_d;
    logic [CW-1:0]        r_rx_cnt, w_rx_cnt_d;
    logic [BW-1:0]        r_rx_bit, w_rx_bit_d;
    logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_d;
    logic                 w_push, w_frame_bad;

    tx_state_t            r_tx_state, w_tx_state_d;
    logic [CW-1:0]        r_tx_cnt, w_tx_cnt_d;
    logic [BW-1:0]        r_tx_bit, w_tx_bit_d;
    logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_d;
    logic                 r_tx, w_tx_d, w_pop;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
    logic [AW:0]          r_count;
    logic                 w_wr_en, w_drop;
    logic [DATA_BITS-1:0] w_rd_data;
    logic                 r_overflow, r_frame_err;

    // r_rx_prev turns the synchronised level into a falling-edge detect for start bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    always_comb begin
        w_rx_state_d = r_rx_state;
        w_rx_cnt_d   = r_rx_cnt;
        w_rx_bit_d   = r_rx_bit;
        w_rx_shift_d = r_rx_shift;
        w_push       = 1'b0;
        w_frame_bad  = 1'b0;
        case (r_rx_state)
            R_IDLE: begin
                w_rx_cnt_d = '0;
                w_rx_bit_d = '0;
                if (r_rx_prev && !r_rx_sync) w_rx_state_d = R_START;
            end
            R_START: begin
                if (r_rx_cnt == HALF_M1) begin
                    w_rx_cnt_d   = '0;
                    w_rx_state_d = r_rx_sync ? R_IDLE : R_DATA;
                end else begin
                    w_rx_cnt_d = r_rx_cnt + 1'b1;
                end
            end
            R_DATA: begin
                if (r_rx_cnt == BIT_M1) begin
                    w_rx_cnt_d   = '0;
                    w_rx_shift_d = {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
                    if (r_rx_bit == LAST_BIT) w_rx_state_d = R_STOP;
                    else                      w_rx_bit_d   = r_rx_bit + 1'b1;
                end else begin
                    w_rx_cnt_d = r_rx_cnt + 1'b1;
                end
            end
            R_STOP: begin
                if (r_rx_cnt == BIT_M1) begin
                    w_rx_cnt_d   = '0;
                    w_rx_state_d = R_IDLE;
                    w_push       = r_rx_sync;
                    w_frame_bad  = !r_rx_sync;
                end else begin
                    w_rx_cnt_d = r_rx_cnt + 1'b1;
                end
            end
            default: w_rx_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_state <= R_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_state <= w_rx_state_d;
            r_rx_cnt   <= w_rx_cnt_d;
            r_rx_bit   <= w_rx_bit_d;
            r_rx_shift <= w_rx_shift_d;
        end
    end

    // A pop in the same cycle frees the slot the full FIFO would otherwise lack.
    assign w_wr_en   = w_push && ((r_count != FULL) || w_pop);
    assign w_drop    = w_push && !w_wr_en;
    assign w_rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= r_rx_shift;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_wr_en && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_wr_en && w_pop) r_count <= r_count - 1'b1;
            r_overflow  <= w_drop | (r_overflow & ~clr_flags);
            r_frame_err <= w_frame_bad | (r_frame_err & ~clr_flags);
        end
    end

    // T_STOP is one cycle short; the T_IDLE cycle completes the stop bit.
    always_comb begin
        w_tx_state_d = r_tx_state;
        w_tx_cnt_d   = r_tx_cnt;
        w_tx_bit_d   = r_tx_bit;
        w_tx_shift_d = r_tx_shift;
        w_pop        = 1'b0;
        w_tx_d       = 1'b1;
        case (r_tx_state)
            T_IDLE: begin
                w_tx_cnt_d = '0;
                w_tx_bit_d = '0;
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_tx_shift_d = w_rd_data;
                    w_tx_state_d = T_START;
                end
            end
            T_START: begin
                w_tx_d = 1'b0;
                if (r_tx_cnt == BIT_M1) begin
                    w_tx_cnt_d   = '0;
                    w_tx_state_d = T_DATA;
                end else begin
                    w_tx_cnt_d = r_tx_cnt + 1'b1;
                end
            end
            T_DATA: begin
                w_tx_d = r_tx_shift[0];
                if (r_tx_cnt == BIT_M1) begin
                    w_tx_cnt_d   = '0;
                    w_tx_shift_d = r_tx_shift >> 1;
                    if (r_tx_bit == LAST_BIT) w_tx_state_d = T_STOP;
                    else                      w_tx_bit_d   = r_tx_bit + 1'b1;
                end else begin
                    w_tx_cnt_d = r_tx_cnt + 1'b1;
                end
            end
            T_STOP: begin
                if (r_tx_cnt == STOP_M1) begin
                    w_tx_cnt_d   = '0;
                    w_tx_state_d = T_IDLE;
                end else begin
                    w_tx_cnt_d = r_tx_cnt + 1'b1;
                end
            end
            default: w_tx_state_d = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state <= T_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_d;
            r_tx_cnt   <= w_tx_cnt_d;
            r_tx_bit   <= w_tx_bit_d;
            r_tx_shift <= w_tx_shift_d;
            r_tx       <= w_tx_d;
        end
    end

    assign tx         = r_tx;
    assign overflow   = r_overflow;
    assign frame_err  = r_frame_err;
    assign fifo_count = r_count;

endmodule

// File: doc/uart_relay_fifo.md
UART_RELAY_FIFO -- requirements
Module: uart_relay_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, the clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115_200, the line rate in bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD (integer divide), minimum 4.
REQ-003 SHALL have parameter DATA_BITS, default 8, the payload width per frame (5..9).
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, the relay buffer entries; a power of 2, minimum 2.
REQ-005 SHALL have port clk  input  1  system clock; one clock domain.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port rx  input  1  serial in, idle high, asynchronous to clk.
REQ-008 SHALL have port tx  output  1  serial out, idle high.
REQ-009 SHALL have port clr_flags  input  1  synchronous one-cycle pulse that clears the sticky flags.
REQ-010 SHALL have port overflow  output  1  sticky flag: a received frame was dropped because the FIFO was full.
REQ-011 SHALL have port frame_err  output  1  sticky flag: a stop bit was sampled low.
REQ-012 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  number of FIFO entries.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer; all receive decisions SHALL use the synchronized value.
REQ-014 Frame format SHALL be 1 start bit (low), DATA_BITS data bits LSB first, 1 stop bit (high), no parity.
REQ-015 RX FSM SHALL have states R_IDLE, R_START, R_DATA and R_STOP.
REQ-016 R_IDLE->R_START SHALL occur on a synchronized low; R_START SHALL re-sample at CLKS_PER_BIT/2 cycles and return to R_IDLE if the line is high (glitch reject), else enter R_DATA.
REQ-017 R_DATA SHALL sample each bit every CLKS_PER_BIT cycles at mid-bit, then enter R_STOP.
REQ-018 R_STOP SHALL sample at mid-bit: high -> push the word; low -> drop the word and set frame_err. Either way SHALL return to R_IDLE on the cycle after the sample, so a start bit beginning right at the end of the stop bit is caught.
REQ-019 A push SHALL be accepted if fifo_count < FIFO_DEPTH or a pop occurs in the same cycle; otherwise the word SHALL be dropped and overflow set.
REQ-020 Simultaneous push and pop SHALL leave fifo_count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 TX FSM SHALL have states T_IDLE, T_START, T_DATA and T_STOP; each bit SHALL last exactly CLKS_PER_BIT cycles.
REQ-022 In T_IDLE with fifo_count != 0 the TX FSM SHALL pop one word and enter T_START; tx SHALL go low on the clock edge following the pop.
REQ-023 End-to-end, the tx falling edge SHALL occur exactly 2 clk cycles after the stop-bit sample edge when the FIFO was empty and TX was idle.
REQ-024 After T_STOP, if the FIFO is non-empty the next pop SHALL occur on the first T_IDLE cycle (back-to-back frames, no extra idle bit time).
REQ-025 tx SHALL be registered and glitch-free.
REQ-026 fifo_count SHALL be registered.
REQ-027 overflow and frame_err SHALL stay set until clr_flags or rst.
REQ-028 clr_flags coinciding with a new set event SHALL leave the flag set (set wins).

Reset
REQ-029 While rst is high: tx=1, overflow=0, frame_err=0, fifo_count=0, both FSMs idle, FIFO pointers 0, synchronizer flops=1.
REQ-030 rst asserted mid-frame SHALL abort both frames; no partial word SHALL be pushed, and tx SHALL return to 1 immediately (asynchronous).
REQ-031 After rst deasserts, the first frame SHALL be recognised only on a falling edge of synchronized rx.

Verification (CLK_FREQ=50e6, BAUD=5e6 -> CLKS_PER_BIT=10; DATA_BITS=8; FIFO_DEPTH=4)
REQ-032 Single byte 0xA5 on rx -> identical 0xA5 frame on tx; tx falls 2 cycles after the stop sample; fifo_count returns to 0; flags 0.
REQ-033 Back-to-back 0x00, 0xFF, 0x3C with no idle gap -> three tx frames with no idle gap; byte order preserved.
REQ-034 Six frames while tx is busy -> first frame in transmission, 4 buffered, 1 dropped; overflow=1; clr_flags pulse -> overflow=0.
REQ-035 Frame 0x55 with stop bit low -> no tx frame, frame_err=1; following valid 0x12 relayed normally.
REQ-036 rx low pulse of 3 cycles -> R_IDLE recovered, nothing pushed, tx stays 1.
REQ-037 rst asserted in the middle of the tx data bits -> tx=1 at once, fifo_count=0; a fresh 0x7E after reset relays correctly.
